plot_arbiter: RTL
=================

// Module: plot_arbiter
// PURPOSE
//   Shares the single VGA pixel-write port (VGA_X/VGA_Y/VGA_COLOR/plot) of the
//   Piano-Tiles display among NREQ rectangle-fill requesters (background clear,
//   falling tiles, hit flash). It grants one request at a time, round-robin,
//   and emits one pixel per clock until the granted rectangle is filled.
//   Sits between the game logic inside display and the VGA adapter outputs.
// PARAMETERS
//   NREQ     3    number of requesters (1..8)
//   SCR_W    160  screen width in pixels; x >= SCR_W is clipped
//   SCR_H    120  screen height in pixels; y >= SCR_H is clipped
// PORTS
//   CLOCK_50   in   1        system clock, 50 MHz, rising edge
//   reset      in   1        asynchronous reset, active-high
//   req        in   NREQ     req[i]=1: requester i wants a fill; held until done[i]
//   rect_x     in   8*NREQ   slice i [8i+7:8i]: left x
//   rect_y     in   7*NREQ   slice i: top y
//   rect_w     in   8*NREQ   slice i: width in pixels (0 = empty)
//   rect_h     in   7*NREQ   slice i: height in pixels (0 = empty)
//   rect_color in   3*NREQ   slice i: 3-bit RGB fill colour
//   done       out  NREQ     one-cycle pulse on done[i] when fill i completes
//   busy       out  1        1 in any state other than IDLE
//   VGA_X      out  8        pixel x
//   VGA_Y      out  7        pixel y
//   VGA_COLOR  out  3        pixel colour
//   plot       out  1        1 = write (VGA_X,VGA_Y,VGA_COLOR) this cycle
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE; plot=0, done=0, busy=0, VGA_X=0,
//     VGA_Y=0, VGA_COLOR=0; round-robin pointer=0. Reset mid-DRAW abandons the
//     fill silently (no done pulse); requester keeps req high and is re-served.
//   - FSM: IDLE -> GRANT -> DRAW -> DONE -> IDLE.
//     IDLE: if |req, winner = first i with req[i] searching from pointer upward
//       (wrapping); go GRANT. Else stay.
//     GRANT (1 cycle): latch winner's x,y,w,h,colour; cx=x, cy=y, plot=0.
//       If w==0 or h==0 go DONE directly (no pixels).
//     DRAW: drive VGA_X=cx, VGA_Y=cy, VGA_COLOR=colour, plot=1 unless
//       cx>=SCR_W or cy>=SCR_H (then plot=0, counters still advance).
//       Raster order: cx increments; at cx==x+w-1 cx<=x, cy increments;
//       at last pixel (x+w-1, y+h-1) go DONE.
//     DONE (1 cycle): done[winner]=1, plot=0; pointer <= winner+1 mod NREQ.
//   - Latency: req rising in IDLE at cycle 0 -> GRANT cycle 1 -> first plot
//     cycle 2; w*h pixels on consecutive cycles; done at cycle 2+w*h.
//     Empty rect: done at cycle 2. Back-to-back grant turnaround: 2 idle cycles.
//   - Handshake: req[i] and fields must stay stable from assertion until done[i];
//     fields are latched in GRANT so changes during DRAW have no effect.
//     Requester must drop req[i] the cycle after done[i]; req still high in IDLE
//     is treated as a new request (round-robin still applies).
//   - Arithmetic: end coordinates x+w-1 and y+h-1 computed 9/8 bits wide so
//     rectangles crossing 255/127 wrap nothing: out-of-range pixels are clipped,
//     never wrapped onto screen. Pixel counters are 9 and 8 bits.
//   - Simultaneous req: only the winner advances; others wait, no loss.
//   - Outputs registered; VGA_* hold last value when plot=0.
// STRUCTURE
//   Shared package plot_pkg: SCR_W/SCR_H defaults, coordinate/colour widths,
//   FSM state encoding (IDLE, GRANT, DRAW, DONE).
//   One sub-module: rr_arbiter (NREQ-wide rotating-priority one-hot pick,
//   combinational, pointer input) instanced by plot_arbiter; rest inline.
// TESTING
//   1 Single req[0], x=10,y=5,w=3,h=2,c=3'b100 -> plot at (10,5)(11,5)(12,5)
//     (10,6)(11,6)(12,6) cycles 2..7, colour 100; done[0] at cycle 8 only.
//   2 req=3'b111 all w=h=1, held -> grants in order 0,1,2; after done[2], pointer
//     back to 0; each done pulse exactly 1 cycle, plot never overlaps requesters.
//   3 Clipping: x=158,y=119,w=4,h=2 -> plot=1 only at (158,119),(159,119); 8 DRAW
//     cycles total, done after all 8.
//   4 Empty: w=0,h=5 -> zero plot cycles, done at cycle 2; w=5,h=0 same.
//   5 Reset asserted mid-DRAW of 10x10 fill -> plot/busy/done drop immediately
//     (async); after release with req still high, fill restarts at (x,y).
//   6 Fairness: req[0] re-asserted every cycle after done, req[2] held -> req[2]
//     granted before req[0]'s second fill; field change during DRAW ignored.

Source files
------------

// File: rtl/plot_pkg.sv
// plot_pkg: constants and types shared by the pixel-plot arbiter.
//   - default screen size (SCR_W_DEF x SCR_H_DEF)
//   - VGA coordinate/colour widths and internal counter widths
//   - FSM state encoding for plot_arbiter
//   - ptr_w(): round-robin pointer width for a given requester count
package plot_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  localparam int X_W  = 8;  // VGA_X / rect_x / rect_w
  localparam int Y_W  = 7;  // VGA_Y / rect_y / rect_h
  localparam int C_W  = 3;  // 3-bit RGB
  localparam int CX_W = 9;  // x counter: holds x+w-1 up to 509
  localparam int CY_W = 8;  // y counter: holds y+h-1 up to 253

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pointer/index width; a single requester still needs a 1-bit index.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
//   req     in  NREQ  request vector
//   ptr     in  PW    index that has highest priority this round
//   gnt     out NREQ  one-hot grant (all zero when no request)
//   gnt_idx out PW    index of the granted requester
// Search order is ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
module rr_arbiter
  import plot_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  // Requests at or above the pointer take precedence over wrapped ones.
  logic [NREQ-1:0] hi;

  always_comb begin
    hi      = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      hi[i] = req[i] & (PW'(i) >= ptr);
    // Scan downward so the lowest set index is the last one written.
    if (|hi) begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (hi[i]) begin
          gnt     = '0;
          gnt[i]  = 1'b1;
          gnt_idx = PW'(i);
        end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (req[i]) begin
          gnt     = '0;
          gnt[i]  = 1'b1;
          gnt_idx = PW'(i);
        end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single VGA pixel-write port among NREQ
// rectangle-fill requesters, round-robin, one pixel per clock.
//   CLOCK_50    in   clock, rising edge
//   reset       in   async reset, active-high
//   req         in   NREQ     per-requester fill request, held until done
//   rect_x/y    in   8/7 bits per requester: top-left corner
//   rect_w/h    in   8/7 bits per requester: size (0 = empty fill)
//   rect_color  in   3 bits per requester
//   done        out  NREQ     1-cycle pulse when that requester's fill ends
//   busy        out  high whenever the FSM is not IDLE
//   VGA_X/Y/COLOR, plot  out  registered pixel write port
// Off-screen pixels (x >= SCR_W or y >= SCR_H) still take a cycle but are
// not plotted; VGA_* hold their last value whenever plot is low.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [X_W*NREQ-1:0]   rect_x,
  input  logic [Y_W*NREQ-1:0]   rect_y,
  input  logic [X_W*NREQ-1:0]   rect_w,
  input  logic [Y_W*NREQ-1:0]   rect_h,
  input  logic [C_W*NREQ-1:0]   rect_color,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [X_W-1:0]        VGA_X,
  output logic [Y_W-1:0]        VGA_Y,
  output logic [C_W-1:0]        VGA_COLOR,
  output logic                  plot
);

  localparam int PW = ptr_w(NREQ);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;      // granted index
  logic [NREQ-1:0]   win_oh;   // granted one-hot, drives done
  logic [NREQ-1:0]   pick_oh;
  logic [PW-1:0]     pick_idx;

  // Latched rectangle (fields are frozen in GRANT)
  logic [X_W-1:0]    lx;
  logic [C_W-1:0]    col;
  logic [CX_W-1:0]   ex;       // last column x+w-1
  logic [CY_W-1:0]   ey;       // last row y+h-1
  logic [CX_W-1:0]   cx;
  logic [CY_W-1:0]   cy;

  // Winner's live fields, used only in GRANT
  logic [X_W-1:0]    fx, fw;
  logic [Y_W-1:0]    fy, fh;
  logic [C_W-1:0]    fc;

  logic [CX_W-1:0]   nx;
  logic [CY_W-1:0]   ny;
  logic              last;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    fx = '0; fy = '0; fw = '0; fh = '0; fc = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == PW'(i)) begin
        fx = rect_x[i*X_W +: X_W];
        fy = rect_y[i*Y_W +: Y_W];
        fw = rect_w[i*X_W +: X_W];
        fh = rect_h[i*Y_W +: Y_W];
        fc = rect_color[i*C_W +: C_W];
      end
  end

  // Raster step from the pixel currently on the port to the next one.
  always_comb begin
    last = (cx == ex) && (cy == ey);
    if (cx == ex) begin
      nx = {1'b0, lx};
      ny = cy + 8'd1;
    end else begin
      nx = cx + 9'd1;
      ny = cy;
    end
  end

  function automatic logic on_screen(input logic [CX_W-1:0] x,
                                     input logic [CY_W-1:0] y);
    return (x < CX_W'(SCR_W)) && (y < CY_W'(SCR_H));
  endfunction

  // Outputs are registered, so the first pixel is loaded on the GRANT edge
  // and each DRAW edge loads the following pixel; DRAW cycles therefore line
  // up one-to-one with pixels on the port.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      win_oh    <= '0;
      lx        <= '0;
      col       <= '0;
      ex        <= '0;
      ey        <= '0;
      cx        <= '0;
      cy        <= '0;
      done      <= '0;
      busy      <= 1'b0;
      plot      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          plot <= 1'b0;
          if (|req) begin
            win    <= pick_idx;
            win_oh <= pick_oh;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end

        GRANT: begin
          lx  <= fx;
          col <= fc;
          ex  <= {1'b0, fx} + {1'b0, fw} - 9'd1;
          ey  <= {1'b0, fy} + {1'b0, fh} - 8'd1;
          if (fw == '0 || fh == '0) begin
            plot  <= 1'b0;
            done  <= win_oh;
            state <= DONE;
          end else begin
            cx    <= {1'b0, fx};
            cy    <= {1'b0, fy};
            state <= DRAW;
            if (on_screen({1'b0, fx}, {1'b0, fy})) begin
              plot      <= 1'b1;
              VGA_X     <= fx;
              VGA_Y     <= fy;
              VGA_COLOR <= fc;
            end else begin
              plot <= 1'b0;
            end
          end
        end

        DRAW: begin
          if (last) begin
            plot  <= 1'b0;
            done  <= win_oh;
            state <= DONE;
          end else begin
            cx <= nx;
            cy <= ny;
            if (on_screen(nx, ny)) begin
              plot      <= 1'b1;
              VGA_X     <= nx[X_W-1:0];
              VGA_Y     <= ny[Y_W-1:0];
              VGA_COLOR <= col;
            end else begin
              plot <= 1'b0;
            end
          end
        end

        DONE: begin
          done  <= '0;
          plot  <= 1'b0;
          busy  <= 1'b0;
          ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
